risc_mem_arbiter: RTL and testbench
===================================

// Module: risc_mem_arbiter
// PURPOSE
//   Shares one single-port synchronous memory between the RISC core's
//   instruction fetch (IF) and data access (DM) stages.
//   - Sequences each access through a small FSM and returns read data with a one-cycle valid pulse.
//   - Drives stall lines back to the pipeline.
//   - Data has priority; a streak limit stops fetch being starved.
// PARAMETERS
//   AW            32  address width (byte address, passed through unchanged)
//   DW            32  data width
//   MEM_LAT       1   memory read latency in cycles, >=1 (mem_rdata valid MEM_LAT cycles after mem_en)
//   MAX_DM_STREAK 4   max consecutive DM grants while if_req pending, >=1
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-low (0 = reset)
//   if_req     in   1   fetch request; held until if_valid
//   if_addr    in   AW  fetch address; stable while if_req
//   if_rdata   out  DW  fetched instruction, valid with if_valid
//   if_valid   out  1   one-cycle completion pulse for IF
//   if_stall   out  1   if_req & ~if_valid (combinational)
//   dm_req     in   1   data request; held until dm_valid
//   dm_we      in   1   1 = store, 0 = load; stable while dm_req
//   dm_addr    in   AW  data address
//   dm_wdata   in   DW  store data
//   dm_rdata   out  DW  load data, valid with dm_valid
//   dm_valid   out  1   one-cycle completion pulse for DM
//   dm_stall   out  1   dm_req & ~dm_valid (combinational)
//   mem_en     out  1   memory access strobe, one cycle per access
//   mem_we     out  1   memory write enable (qualified by mem_en)
//   mem_addr   out  AW  registered access address
//   mem_wdata  out  DW  registered write data
//   mem_rdata  in   DW  memory read data
//   busy       out  1   FSM not in IDLE
// BEHAVIOUR
//   Reset values: all registered outputs 0, FSM=IDLE, owner=IF, streak=0.
//   FSM states: IDLE -> ACCESS -> {WAIT -> DONE | DONE} -> IDLE
//   - IDLE: if any req, pick winner, latch owner/addr/we/wdata; go ACCESS.
//   - ACCESS: mem_en=1, mem_we=latched we. Store goes DONE; load loads wait_cnt=MEM_LAT and goes WAIT.
//   - WAIT: decrement wait_cnt. On the edge where it reaches 0, register mem_rdata into
//     owner's rdata and go DONE.
//   - DONE: assert owner's valid for exactly one cycle; go IDLE.
//     A new request is never taken in DONE.
//   Latency: load req first seen in cycle t gives valid in cycle t+2+MEM_LAT; store gives valid in t+2.
//   Fetch requests are always loads (mem_we=0).
//   Arbitration is evaluated only in IDLE:
//   - Only one req: it wins.
//   - Both req: DM wins unless streak==MAX_DM_STREAK, in which case IF wins.
//   - Streak: +1 on a DM grant while if_req=1; cleared on any IF grant; saturates.
//   rdata outputs hold their value until the next completion for the same port.
//   Protocol violations:
//   - Dropped req mid-access: the access completes and valid still pulses.
//   - Address change mid-access: ignored; the latched values are used.
//   Reset mid-operation: FSM returns to IDLE immediately and no valid is issued.
//   A store whose mem_en already fired is not undone.
//   No combinational path from the memory to the core: rdata and valid are registered.
// STRUCTURE
//   risc_defs.vh (shared include):
//   - FSM state encodings ST_IDLE/ST_ACCESS/ST_WAIT/ST_DONE
//   - owner encodings OWN_IF/OWN_DM
//   Sub-module risc_arb_pick: combinational winner select plus the streak counter.
//   Top holds the FSM, the latches and wait_cnt.
// TESTING
//   1 reset=0 then 1; no req -> all outputs 0, busy=0 for 10 cycles.
//   2 IF read 0x0000_0010, MEM_LAT=1, mem returns 0x0000_0093
//     -> mem_en at t+1, if_valid at t+3, if_rdata=0x93, if_stall 1 for t..t+2.
//   3 DM store addr 0x40 data 0xDEADBEEF -> mem_en&mem_we at t+1, dm_valid at t+2;
//     then IF/DM load 0x40 -> rdata 0xDEADBEEF.
//   4 if_req and dm_req both held, DM reissues on each valid, MAX_DM_STREAK=4
//     -> grant order DM,DM,DM,DM,IF,DM...
//   5 MEM_LAT=3, DM load -> dm_valid exactly at t+5; one pulse only.
//   6 reset asserted during WAIT -> busy=0 and no valid pulse;
//     after release, a pending IF req is served normally.

Source files
------------

// File: rtl/risc_mem_arbiter_pkg.sv
// Shared encodings for the IF/DM memory arbiter.
// No logic: FSM state and access-owner encodings used across the block.
// No flow control of its own.
package risc_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/risc_mem_arbiter_if.sv
// Bundle of the core-side (IF/DM) request ports and the memory-side port.
// No latency: wires only.
// Requests are held by the core until the matching valid pulse.
interface risc_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          dm_stall;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Core + memory side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/risc_mem_arbiter_arb_pick.sv
// Winner select between fetch and data requests, with anti-starvation streak counter.
// Combinational grant; streak updates on the clock edge where a grant is taken.
// Data wins ties until it has won MAX_DM_STREAK times in a row over a waiting fetch.
module risc_mem_arbiter_arb_pick #(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_req_i,
    input  logic dm_req_i,
    input  logic take_i,
    output logic grant_vld_o,
    output logic grant_dm_o
);

    localparam int SW = $clog2(MAX_DM_STREAK + 1);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          at_limit;

    assign at_limit    = (streak_q == SW'(MAX_DM_STREAK));
    assign grant_vld_o = if_req_i | dm_req_i;
    assign grant_dm_o  = dm_req_i & ~(if_req_i & at_limit);

    // Next streak: count DM wins over a waiting fetch, clear on any fetch win, saturate.
    always_comb begin
        streak_d = streak_q;
        if (take_i && grant_vld_o) begin
            if (!grant_dm_o) begin
                streak_d = '0;
            end else if (if_req_i && !at_limit) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    // Streak register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/risc_mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data access.
// Latency: load valid at t+2+MEM_LAT, store valid at t+2 after the request is first seen.
// Core requests stall (held) until their valid pulse; one access in flight at a time.
module risc_mem_arbiter
    import risc_mem_arbiter_pkg::*;
#(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MEM_LAT       = 1,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    risc_mem_arbiter_if.slave  bus,
    output logic               busy_o
);

    localparam int CW = $clog2(MEM_LAT + 1);

    state_e        state_q;
    owner_e        owner_q;
    logic [CW-1:0] wait_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          if_valid_q;
    logic          dm_valid_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;

    logic          grant_vld;
    logic          grant_dm;

    risc_mem_arbiter_arb_pick #(
        .MAX_DM_STREAK (MAX_DM_STREAK)
    ) u_pick (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .if_req_i    (bus.if_req),
        .dm_req_i    (bus.dm_req),
        .take_i      (state_q == ST_IDLE),
        .grant_vld_o (grant_vld),
        .grant_dm_o  (grant_dm)
    );

    // Access sequencer: latch the winner in IDLE, strobe memory, wait out read latency, pulse valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            wait_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            mem_en_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        owner_q    <= grant_dm ? OWN_DM : OWN_IF;
                        mem_addr_q <= grant_dm ? bus.dm_addr : bus.if_addr;
                        mem_we_q   <= grant_dm & bus.dm_we;
                        if (grant_dm) begin
                            mem_wdata_q <= bus.dm_wdata;
                        end
                        mem_en_q <= 1'b1;
                        state_q  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        // Store: nothing to read back, complete straight away.
                        if_valid_q <= (owner_q == OWN_IF);
                        dm_valid_q <= (owner_q == OWN_DM);
                        state_q    <= ST_DONE;
                    end else begin
                        wait_q  <= CW'(MEM_LAT);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_q <= wait_q - 1'b1;
                    if (wait_q == CW'(1)) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_valid_q <= 1'b1;
                        end else begin
                            dm_rdata_q <= bus.mem_rdata;
                            dm_valid_q <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    // DONE: valid is high this cycle; no new grant until back in IDLE.
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.if_stall  = bus.if_req & ~if_valid_q;
    assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Scoreboard bench for risc_mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
// Stimulus pushes expected responses and memory strobes; a negedge monitor pops and compares.
// Each DUT has a small behavioural memory model returning a marker value outside read slots.
module tb_risc_mem_arbiter;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
        bit          chk_d;
    } rexp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdat;
    } mexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy1, busy3;
    int   cyc = 0;
    int   nchk = 0;
    int   nbad = 0;

    // Response queues: 0=if1 1=dm1 2=if3 3=dm3; memory-strobe queues: 0=dut1 1=dut3
    rexp_t rq[4][$];
    mexp_t mq[2][$];
    string rname[4] = '{"if1", "dm1", "if3", "dm3"};

    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] p3   [0:2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    risc_mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
    risc_mem_arbiter_if #(.AW(32), .DW(32)) b3 ();

    risc_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_DM_STREAK(4)) u_dut1 (
        .clk_i (clk), .rst_ni (rst_n), .bus (b1), .busy_o (busy1)
    );
    risc_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_DM_STREAK(4)) u_dut3 (
        .clk_i (clk), .rst_ni (rst_n), .bus (b3), .busy_o (busy3)
    );

    // Memory models: MEM_LAT=1 single register, MEM_LAT=3 three-stage pipe.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 32'h0;
                mem3[i] <= 32'h0;
            end
            mem1[4]  <= 32'h0000_0093;
            mem3[4]  <= 32'h0000_0093;
            mem3[32] <= 32'hCAFE_0005;
        end else begin
            if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[9:2]] <= b1.mem_wdata;
            if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr[9:2]] <= b3.mem_wdata;
        end
        b1.mem_rdata <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr[9:2]] : 32'hBAD0_BAD0;
        p3[0] <= (b3.mem_en && !b3.mem_we) ? mem3[b3.mem_addr[9:2]] : 32'hBAD0_BAD0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b3.mem_rdata = p3[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic valid_of(input int i);
        case (i)
            0:       return b1.if_valid;
            1:       return b1.dm_valid;
            2:       return b3.if_valid;
            default: return b3.dm_valid;
        endcase
    endfunction

    // Wait (bounded) for a valid pulse, then return #1 after the following edge.
    task automatic wait_valid(input int i, input string nm);
        int n = 0;
        @(negedge clk);
        while (!valid_of(i) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_completed"}, {31'd0, valid_of(i)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every valid pulse and every memory strobe.
    logic [3:0]  mv;
    logic [31:0] md [4];
    logic [1:0]  men, mwe;
    logic [31:0] maddr [2];
    logic [31:0] mwd [2];
    rexp_t       re;
    mexp_t       me;
    always @(negedge clk) begin
        mv    = {b3.dm_valid, b3.if_valid, b1.dm_valid, b1.if_valid};
        md[0] = b1.if_rdata; md[1] = b1.dm_rdata; md[2] = b3.if_rdata; md[3] = b3.dm_rdata;
        men   = {b3.mem_en, b1.mem_en};
        mwe   = {b3.mem_we, b1.mem_we};
        maddr[0] = b1.mem_addr;  maddr[1] = b3.mem_addr;
        mwd[0]   = b1.mem_wdata; mwd[1]   = b3.mem_wdata;
        for (int i = 0; i < 4; i++) begin
            if (mv[i]) begin
                if (rq[i].size() == 0) begin
                    chk({rname[i], "_unexpected_valid"}, {31'd0, mv[i]}, 32'd0);
                end else begin
                    re = rq[i].pop_front();
                    if (re.cyc >= 0) chk({rname[i], "_valid_cycle"}, cyc, re.cyc);
                    if (re.chk_d) chk({rname[i], "_rdata"}, md[i], re.dat);
                end
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (men[j]) begin
                if (mq[j].size() == 0) begin
                    chk($sformatf("mem%0d_unexpected_en", j), {31'd0, men[j]}, 32'd0);
                end else begin
                    me = mq[j].pop_front();
                    if (me.cyc >= 0) chk($sformatf("mem%0d_en_cycle", j), cyc, me.cyc);
                    chk($sformatf("mem%0d_addr", j), maddr[j], me.addr);
                    chk($sformatf("mem%0d_we", j), {31'd0, mwe[j]}, {31'd0, me.we});
                    if (me.we) chk($sformatf("mem%0d_wdata", j), mwd[j], me.wdat);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    int t;
    int r;
    initial begin
        b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_addr = 0; b3.dm_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: idle after reset
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_outputs", {26'd0, busy1, busy3, b1.mem_en, b1.if_valid | b1.dm_valid,
                                 b1.if_stall | b1.dm_stall, b3.mem_en | b3.if_valid | b3.dm_valid},
                32'd0);
        end
        chk("reset_rdata", b1.if_rdata | b1.dm_rdata | b1.mem_addr | b1.mem_wdata, 32'd0);

        // 2: IF read 0x10 on MEM_LAT=1 -> 0x93 at t+3, stall t..t+2
        @(posedge clk); #1;
        t = cyc;
        b1.if_req = 1; b1.if_addr = 32'h10;
        mq[0].push_back('{t + 1, 1'b0, 32'h10, 32'h0});
        rq[0].push_back('{t + 3, 32'h0000_0093, 1'b1});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("if_stall_t%0d", k), {31'd0, b1.if_stall}, (k < 3) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        b1.if_req = 0;

        // 3: DM store 0x40, then IF load and DM load of 0x40
        t = cyc;
        b1.dm_req = 1; b1.dm_we = 1; b1.dm_addr = 32'h40; b1.dm_wdata = 32'hDEAD_BEEF;
        mq[0].push_back('{t + 1, 1'b1, 32'h40, 32'hDEAD_BEEF});
        rq[1].push_back('{t + 2, 32'h0, 1'b0});
        wait_valid(1, "dm_store");
        b1.dm_req = 0; b1.dm_we = 0;
        chk("if_rdata_hold_after_store", b1.if_rdata, 32'h0000_0093);
        t = cyc;
        b1.if_req = 1; b1.if_addr = 32'h40;
        mq[0].push_back('{t + 1, 1'b0, 32'h40, 32'h0});
        rq[0].push_back('{t + 3, 32'hDEAD_BEEF, 1'b1});
        wait_valid(0, "if_load40");
        b1.if_req = 0;
        t = cyc;
        b1.dm_req = 1; b1.dm_addr = 32'h40;
        mq[0].push_back('{t + 1, 1'b0, 32'h40, 32'h0});
        rq[1].push_back('{t + 3, 32'hDEAD_BEEF, 1'b1});
        wait_valid(1, "dm_load40");
        b1.dm_req = 0;

        // 4: both held, DM restreams stores -> DM x4, IF, DM
        t = cyc;
        for (int k = 0; k < 4; k++)
            mq[0].push_back('{t + 1 + 3 * k, 1'b1, 32'h200 + 4 * k, 32'hA0 + k});
        mq[0].push_back('{t + 13, 1'b0, 32'h10, 32'h0});
        mq[0].push_back('{t + 17, 1'b1, 32'h210, 32'hA4});
        for (int k = 0; k < 4; k++) rq[1].push_back('{t + 2 + 3 * k, 32'h0, 1'b0});
        rq[0].push_back('{t + 15, 32'h0000_0093, 1'b1});
        rq[1].push_back('{t + 18, 32'h0, 1'b0});
        b1.if_req = 1; b1.if_addr = 32'h10;
        b1.dm_req = 1; b1.dm_we = 1;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    b1.dm_addr  = 32'h200 + 4 * k;
                    b1.dm_wdata = 32'hA0 + k;
                    wait_valid(1, "dm_stream");
                end
                b1.dm_req = 0; b1.dm_we = 0;
            end
            begin
                wait_valid(0, "if_starved");
                b1.if_req = 0;
            end
        join

        // 5: MEM_LAT=3 DM load -> valid at t+5, single pulse
        t = cyc;
        b3.dm_req = 1; b3.dm_we = 0; b3.dm_addr = 32'h80;
        mq[1].push_back('{t + 1, 1'b0, 32'h80, 32'h0});
        rq[3].push_back('{t + 5, 32'hCAFE_0005, 1'b1});
        wait_valid(3, "dm_lat3");
        b3.dm_req = 0;
        @(negedge clk);
        chk("dm_lat3_single_pulse", {31'd0, b3.dm_valid}, 32'd0);

        // 6: reset during WAIT, pending IF served after release
        @(posedge clk); #1;
        t = cyc;
        b3.dm_req = 1; b3.dm_addr = 32'h80; b3.if_req = 1; b3.if_addr = 32'h10;
        mq[1].push_back('{t + 1, 1'b0, 32'h80, 32'h0});
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        b3.dm_req = 0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy3}, 32'd0);
        chk("reset_outputs", {29'd0, b3.mem_en, b3.dm_valid, b3.if_valid}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        r = cyc;
        mq[1].push_back('{r + 1, 1'b0, 32'h10, 32'h0});
        rq[2].push_back('{r + 5, 32'h0000_0093, 1'b1});
        wait_valid(2, "if_after_reset");
        b3.if_req = 0;

        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) chk({rname[i], "_leftover"}, rq[i].size(), 32'd0);
        for (int j = 0; j < 2; j++) chk($sformatf("mem%0d_leftover", j), mq[j].size(), 32'd0);
        chk("final_busy", {30'd0, busy1, busy3}, 32'd0);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
